// File: rtl/exec_stage_unit.sv
// Execute-stage slice: free-running stage counter, ALU control mapper and 32-bit ALU.
// Define EXE_RESULT_REG_EN to register alu_result (1-cycle latency); otherwise it is combinational.
module exec_stage_unit #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         alu_operation,
    input  logic [31:0]        reg_value_0,
    input  logic [31:0]        reg_value_1,
    output logic [STAGE_W-1:0] current_stage,
    output logic [4:0]         alu_op_select,
    output logic [31:0]        alu_in0,
    output logic [31:0]        alu_in1,
    output logic [31:0]        alu_result,
    output logic               alu_zero
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    localparam logic [4:0] OP_INC  = 5'd16;
    localparam logic [4:0] OP_DEC  = 5'd17;
    localparam logic [4:0] OP_MOV  = 5'd18;
    localparam logic [4:0] OP_NEG  = 5'd19;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    logic [STAGE_W-1:0] stage_p0;
    logic [31:0]        alu_out_p0;

    function automatic logic [31:0] alu_eval(
        input logic [4:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic signed [31:0] a_s;
        logic signed [31:0] b_s;
        logic        [4:0]  shamt;
        a_s   = signed'(a);
        b_s   = signed'(b);
        shamt = b[4:0];
        case (op)
            OP_ADD:  alu_eval = a + b;
            OP_SUB:  alu_eval = a - b;
            OP_AND:  alu_eval = a & b;
            OP_OR:   alu_eval = a | b;
            OP_XOR:  alu_eval = a ^ b;
            OP_SLL:  alu_eval = a << shamt;
            OP_SRL:  alu_eval = a >> shamt;
            OP_SRA:  alu_eval = unsigned'(a_s >>> shamt);
            OP_SLT:  alu_eval = {31'd0, (a_s < b_s)};
            OP_SLTU: alu_eval = {31'd0, (a < b)};
            default: alu_eval = 32'd0;
        endcase
    endfunction

    // Stage 0: pipeline stage counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_p0 <= '0;
        end else if (stage_p0 == LAST_STAGE) begin
            stage_p0 <= '0;
        end else begin
            stage_p0 <= stage_p0 + 1'b1;
        end
    end

    assign current_stage = stage_p0;

    // Stage 0: opcode/operand mapping; pseudo-ops reuse ADD/SUB with constant operands
    always_comb begin
        alu_op_select = OP_ADD;
        alu_in0       = 32'd0;
        alu_in1       = 32'd0;
        case (alu_operation)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU: begin
                alu_op_select = alu_operation;
                alu_in0       = reg_value_0;
                alu_in1       = reg_value_1;
            end
            OP_INC: begin
                alu_op_select = OP_ADD;
                alu_in0       = reg_value_0;
                alu_in1       = 32'd1;
            end
            OP_DEC: begin
                alu_op_select = OP_SUB;
                alu_in0       = reg_value_0;
                alu_in1       = 32'd1;
            end
            OP_MOV: begin
                alu_op_select = OP_ADD;
                alu_in0       = reg_value_0;
                alu_in1       = 32'd0;
            end
            OP_NEG: begin
                alu_op_select = OP_SUB;
                alu_in0       = 32'd0;
                alu_in1       = reg_value_0;
            end
            default: begin
                alu_op_select = OP_ADD;
                alu_in0       = 32'd0;
                alu_in1       = 32'd0;
            end
        endcase
    end

    assign alu_out_p0 = alu_eval(alu_op_select, alu_in0, alu_in1);

`ifdef EXE_RESULT_REG_EN
    logic [31:0] alu_result_p1;

    // Stage 1: result register, loads every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_p1 <= 32'd0;
        end else begin
            alu_result_p1 <= alu_out_p0;
        end
    end

    assign alu_result = alu_result_p1;
`else
    assign alu_result = alu_out_p0;
`endif

    assign alu_zero = (alu_result == 32'd0);

endmodule

// File: tb/tb_exec_stage_unit.sv
// Scoreboard bench for exec_stage_unit: stimulus queues expectations tagged with a due cycle,
// a negedge monitor compares whatever is due. Result latency follows EXE_RESULT_REG_EN.
module tb_exec_stage_unit;

`ifdef EXE_RESULT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    localparam int SEL_RESULT = 0;
    localparam int SEL_ZERO   = 1;
    localparam int SEL_OPSEL  = 2;
    localparam int SEL_IN0    = 3;
    localparam int SEL_IN1    = 4;
    localparam int SEL_STAGE  = 5;

    typedef struct {
        string       name;
        int          due;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alu_operation;
    logic [31:0] reg_value_0;
    logic [31:0] reg_value_1;
    logic [2:0]  current_stage;
    logic [4:0]  alu_op_select;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [31:0] alu_result;
    logic        alu_zero;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    sb_entry_t sb[$];

    exec_stage_unit #(.NUM_STAGES(5), .STAGE_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_operation (alu_operation),
        .reg_value_0   (reg_value_0),
        .reg_value_1   (reg_value_1),
        .current_stage (current_stage),
        .alu_op_select (alu_op_select),
        .alu_in0       (alu_in0),
        .alu_in1       (alu_in1),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string name, input int due, input int sel, input logic [31:0] exp);
        sb_entry_t e;
        e.name = name;
        e.due  = due;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic apply(input string name, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(posedge clk);
        #1;
        alu_operation = op;
        reg_value_0   = a;
        reg_value_1   = b;
        push(name, cyc + LAT, SEL_RESULT, exp);
        push({name, "_zero"}, cyc + LAT, SEL_ZERO, {31'd0, (exp == 32'd0)});
    endtask

    // Monitor: compare every entry that is due this cycle
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].sel)
                    SEL_RESULT: act = alu_result;
                    SEL_ZERO:   act = {31'd0, alu_zero};
                    SEL_OPSEL:  act = {27'd0, alu_op_select};
                    SEL_IN0:    act = alu_in0;
                    SEL_IN1:    act = alu_in1;
                    default:    act = {29'd0, current_stage};
                endcase
                compared++;
                if (act !== sb[i].exp) begin
                    mismatched++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                             sb[i].name, act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        alu_operation = 5'd16;
        reg_value_0   = 32'hFFFF_FFFF;
        reg_value_1   = 32'd0;

        // Two reset edges; combinational mapper still follows inputs
        @(posedge clk); #1;
        @(posedge clk); #1;
        push("rst_stage", cyc, SEL_STAGE, 32'd0);
        push("rst_result", cyc, SEL_RESULT, 32'd0);
        push("rst_zero", cyc, SEL_ZERO, 32'd1);
        push("rst_inc_opsel", cyc, SEL_OPSEL, 32'd0);
        push("rst_inc_in0", cyc, SEL_IN0, 32'hFFFF_FFFF);
        push("rst_inc_in1", cyc, SEL_IN1, 32'd1);
        rst = 1'b0;

        // Count 1,2,3,4,0 then 1,2,3 and reset at stage 3
        for (int i = 1; i <= 8; i++) begin
            push($sformatf("stage_%0d", i), cyc + i, SEL_STAGE, 32'(i % 5));
        end
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        push("stage_midreset", cyc + 1, SEL_STAGE, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        apply("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        apply("sub_wrap", 5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
        apply("sra", 5'd7, 32'h8000_0000, 32'h21, 32'hC000_0000);
        apply("srl", 5'd6, 32'h8000_0000, 32'h21, 32'h4000_0000);
        apply("sll", 5'd5, 32'd1, 32'd31, 32'h8000_0000);
        apply("slt", 5'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
        apply("sltu", 5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
        apply("and", 5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        apply("or", 5'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        apply("xor", 5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        apply("inc", 5'd16, 32'd41, 32'hDEAD_BEEF, 32'd42);
        push("inc_opsel", cyc, SEL_OPSEL, 32'd0);
        push("inc_in1", cyc, SEL_IN1, 32'd1);
        apply("dec", 5'd17, 32'd10, 32'd77, 32'd9);
        push("dec_opsel", cyc, SEL_OPSEL, 32'd1);
        apply("mov", 5'd18, 32'h0000_1234, 32'h5555_5555, 32'h0000_1234);
        push("mov_in1", cyc, SEL_IN1, 32'd0);
        apply("neg", 5'd19, 32'd3, 32'd9, 32'hFFFF_FFFD);
        push("neg_in0", cyc, SEL_IN0, 32'd0);
        push("neg_in1", cyc, SEL_IN1, 32'd3);
        apply("code31", 5'd31, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
        push("code31_opsel", cyc, SEL_OPSEL, 32'd0);
        apply("code12", 5'd12, 32'h1111_1111, 32'h2222_2222, 32'd0);

        // AND under reset: combinational build ignores rst, registered build clears
        @(posedge clk); #1;
        rst           = 1'b1;
        alu_operation = 5'd2;
        reg_value_0   = 32'hF0F0_F0F0;
        reg_value_1   = 32'hFF00_FF00;
`ifdef EXE_RESULT_REG_EN
        push("and_in_reset", cyc + 1, SEL_RESULT, 32'd0);
`else
        push("and_in_reset", cyc, SEL_RESULT, 32'hF000_F000);
`endif
        push("and_in_reset_opsel", cyc, SEL_OPSEL, 32'd2);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
            mismatched += sb.size();
            compared   += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
